pkt_proc_mvc: RTL and testbench
===============================

Name: pkt_proc_mvc

Overview:
Multi-VC packet processor between the AXI slave datapath and the router local port.
- TX: frames AXI write beats into HEAD/BODY/TAIL/HEAD_TAIL flits with independent per-VC packet tracking, so packets on different VCs may interleave beat-by-beat.
- RX: strips flit type for the AXI RX buffer. An optional per-VC protocol checker reports packet completion, length and framing errors.

Parameters:
- NUM_VC, 2, number of virtual channels (≥1); VC_W = max(1, $clog2(NUM_VC)).
- FLIT_DATA_W, 32, payload bits per flit; FLIT_W = FLIT_DATA_W+2 (type in bits [FLIT_W-1:FLIT_W-2]).
- PKT_SZ_W, 8, width of pkt_sz (flits following the head).

Ports:
- clk_axi  in  1  clock
- arst_axi  in  1  asynchronous reset, active-high
- tx_valid_i  in  1  AXI-side beat valid
- tx_ready_o  out  1  beat accepted (= noc_tx_ready_i)
- tx_data_i  in  FLIT_DATA_W  beat payload
- tx_vc_i  in  VC_W  target VC
- tx_pkt_sz_i  in  PKT_SZ_W  flits after head; sampled only on head beats
- tx_busy_o  out  NUM_VC  per-VC packet in progress
- noc_tx_valid_o  out  1  flit valid to router
- noc_tx_ready_i  in  1  router ready
- noc_tx_flit_o  out  FLIT_W  {type, data}
- noc_tx_vc_o  out  VC_W  flit VC
- noc_rx_valid_i  in  1  flit valid from router
- noc_rx_ready_o  out  1  (= rx_ready_i)
- noc_rx_flit_i  in  FLIT_W  incoming flit
- noc_rx_vc_i  in  VC_W  incoming VC
- rx_valid_o  out  1  to AXI RX buffer
- rx_ready_i  in  1  RX buffer ready
- rx_data_o  out  FLIT_DATA_W  flit payload, type stripped
- rx_vc_o  out  VC_W  VC
- rx_pkt_done_o  out  1  registered pulse: packet completed
- rx_pkt_vc_o  out  VC_W  VC of completed packet
- rx_pkt_len_o  out  PKT_SZ_W+1  total flits of completed packet
- rx_err_o  out  NUM_VC  sticky framing error per VC
- rx_err_clr_i  in  NUM_VC  write-1-to-clear for rx_err_o

Behaviour:
- Flit types: HEAD=2'b00, BODY=2'b01, TAIL=2'b10, HEAD_TAIL=2'b11.
- Reset: all per-VC state cleared; tx_busy_o=0, rx_pkt_done_o=0, rx_pkt_vc_o=0, rx_pkt_len_o=0, rx_err_o=0. Combinational outputs follow inputs. Reset mid-packet discards all packet progress; the next beat on any VC is a head.
- TX datapath: zero latency, combinational.
  - noc_tx_valid_o = tx_valid_i; tx_ready_o = noc_tx_ready_i.
  - flit data = tx_data_i; noc_tx_vc_o = tx_vc_i.
- TX type per VC v=tx_vc_i, with busy[v] and cnt[v] (PKT_SZ_W):
  - !busy[v], pkt_sz==0: HEAD_TAIL; no state change.
  - !busy[v], pkt_sz>0: HEAD; on handshake busy[v]<=1, cnt[v]<=pkt_sz.
  - busy[v], cnt[v]>1: BODY; on handshake cnt[v]--.
  - busy[v], cnt[v]==1: TAIL; on handshake busy[v]<=0, cnt[v]<=0.
  - State updates only on handshake (tx_valid_i & noc_tx_ready_i). A stalled beat holds its type.
  - tx_pkt_sz_i is ignored while busy[v]. Other VCs' state is untouched.
- RX datapath: zero latency, combinational.
  - rx_valid_o = noc_rx_valid_i; noc_rx_ready_o = rx_ready_i.
  - rx_data_o = flit[FLIT_DATA_W-1:0]; rx_vc_o = noc_rx_vc_i.
  - All flits are forwarded regardless of checker result.
- RX checker: per VC, in_pkt[v] and len[v] (PKT_SZ_W+1, saturating at all-ones). Acts on RX handshake only.
  - HEAD: if in_pkt, set err[v]; then in_pkt<=1, len<=1.
  - BODY: if !in_pkt, set err[v] and ignore; else len++.
  - TAIL: if !in_pkt, set err[v] and ignore; else done pulse with len+1 (saturating), in_pkt<=0.
  - HEAD_TAIL: if in_pkt, set err[v]; done pulse with len=1, in_pkt<=0.
- Done outputs: rx_pkt_done_o, rx_pkt_vc_o and rx_pkt_len_o are registered, one cycle after the completing handshake. vc/len hold their last value when no pulse.
- Error clear: rx_err_o[v] cleared by rx_err_clr_i[v]; a set in the same cycle wins over clear.

Optional Feature:
PKT_PROC_RX_CHK_EN
- Defined: RX checker present as above.
- Undefined: no checker state. rx_pkt_done_o, rx_pkt_vc_o, rx_pkt_len_o and rx_err_o are tied 0; rx_err_clr_i is ignored. TX and RX datapaths are unchanged.

Test Plan:
- VC0, pkt_sz=3, ready=1, 4 beats → types HEAD, BODY, BODY, TAIL; tx_busy_o[0] is 1 after the head and 0 after the tail.
- pkt_sz=0 on VC1 → single HEAD_TAIL; busy stays 0. RX loopback gives done pulse with vc=1, len=1.
- Interleave VC0 (pkt_sz=2) and VC1 (pkt_sz=1) beats alternately → correct per-VC types. RX done reports VC1 len=2, then VC0 len=3.
- Hold noc_tx_ready_i=0 for 3 cycles on a HEAD beat → type stays HEAD; busy and cnt stay unchanged until ready.
- RX BODY on idle VC0 → rx_err_o=2'b01 and flit still forwarded. Assert rx_err_clr_i=2'b01 in the same cycle as a new VC0 error → err remains 1. Clear alone → 0.
- Assert arst_axi mid-packet (cnt=2) → busy cleared; the next VC0 beat with pkt_sz=1 is typed HEAD.

Source files
------------

// File: rtl/pkt_proc_mvc_if.sv
// Signal bundle for pkt_proc_mvc: AXI-side TX/RX beats, router local port and
// RX checker status. The processor takes the slave view, its environment the master.
interface pkt_proc_mvc_if #(
  parameter int NUM_VC      = 2,
  parameter int FLIT_DATA_W = 32,
  parameter int PKT_SZ_W    = 8
);
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int FLIT_W = FLIT_DATA_W + 2;

  logic                   tx_valid;
  logic                   tx_ready;
  logic [FLIT_DATA_W-1:0] tx_data;
  logic [VC_W-1:0]        tx_vc;
  logic [PKT_SZ_W-1:0]    tx_pkt_sz;
  logic [NUM_VC-1:0]      tx_busy;

  logic                   noc_tx_valid;
  logic                   noc_tx_ready;
  logic [FLIT_W-1:0]      noc_tx_flit;
  logic [VC_W-1:0]        noc_tx_vc;

  logic                   noc_rx_valid;
  logic                   noc_rx_ready;
  logic [FLIT_W-1:0]      noc_rx_flit;
  logic [VC_W-1:0]        noc_rx_vc;

  logic                   rx_valid;
  logic                   rx_ready;
  logic [FLIT_DATA_W-1:0] rx_data;
  logic [VC_W-1:0]        rx_vc;
  logic                   rx_pkt_done;
  logic [VC_W-1:0]        rx_pkt_vc;
  logic [PKT_SZ_W:0]      rx_pkt_len;
  logic [NUM_VC-1:0]      rx_err;
  logic [NUM_VC-1:0]      rx_err_clr;

  modport slave (
    input  tx_valid, tx_data, tx_vc, tx_pkt_sz,
    output tx_ready, tx_busy,
    output noc_tx_valid, noc_tx_flit, noc_tx_vc,
    input  noc_tx_ready,
    input  noc_rx_valid, noc_rx_flit, noc_rx_vc,
    output noc_rx_ready,
    output rx_valid, rx_data, rx_vc,
    input  rx_ready,
    output rx_pkt_done, rx_pkt_vc, rx_pkt_len, rx_err,
    input  rx_err_clr
  );

  modport master (
    output tx_valid, tx_data, tx_vc, tx_pkt_sz,
    input  tx_ready, tx_busy,
    input  noc_tx_valid, noc_tx_flit, noc_tx_vc,
    output noc_tx_ready,
    output noc_rx_valid, noc_rx_flit, noc_rx_vc,
    input  noc_rx_ready,
    input  rx_valid, rx_data, rx_vc,
    output rx_ready,
    input  rx_pkt_done, rx_pkt_vc, rx_pkt_len, rx_err,
    output rx_err_clr
  );
endinterface

// File: rtl/pkt_proc_mvc.sv
// Multi-VC packet processor: frames AXI beats into typed flits per VC and strips
// flit type on receive. Define PKT_PROC_RX_CHK_EN to build the per-VC RX protocol checker.
module pkt_proc_mvc #(
  parameter int NUM_VC      = 2,
  parameter int FLIT_DATA_W = 32,
  parameter int PKT_SZ_W    = 8
) (
  input logic           clk_axi,
  input logic           arst_axi,
  pkt_proc_mvc_if.slave bus
);
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int FLIT_W = FLIT_DATA_W + 2;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  // ---------------- TX framing ----------------
  logic [NUM_VC-1:0]   tx_busy;
  logic [PKT_SZ_W-1:0] tx_cnt [NUM_VC];
  flit_type_e          tx_type;
  logic                tx_hs;

  assign tx_hs = bus.tx_valid & bus.noc_tx_ready;

  // NOTE: every variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    tx_type = HEAD;
    if (!tx_busy[bus.tx_vc])
      tx_type = (bus.tx_pkt_sz == '0) ? HEAD_TAIL : HEAD;
    else if (tx_cnt[bus.tx_vc] > PKT_SZ_W'(1))
      tx_type = BODY;
    else
      tx_type = TAIL;
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      tx_busy <= '0;
      // NOTE: the per-VC counter array is tiny, so it is reset like ordinary flops.
      for (int v = 0; v < NUM_VC; v++) tx_cnt[v] <= '0;
    end else if (tx_hs) begin
      case (tx_type)
        HEAD: begin
          tx_busy[bus.tx_vc] <= 1'b1;
          tx_cnt[bus.tx_vc]  <= bus.tx_pkt_sz;
        end
        BODY: tx_cnt[bus.tx_vc] <= tx_cnt[bus.tx_vc] - PKT_SZ_W'(1);
        TAIL: begin
          tx_busy[bus.tx_vc] <= 1'b0;
          tx_cnt[bus.tx_vc]  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_ready     = bus.noc_tx_ready;
  assign bus.tx_busy      = tx_busy;
  assign bus.noc_tx_valid = bus.tx_valid;
  assign bus.noc_tx_flit  = {tx_type, bus.tx_data};
  assign bus.noc_tx_vc    = bus.tx_vc;

  // ---------------- RX datapath ----------------
  assign bus.rx_valid     = bus.noc_rx_valid;
  assign bus.noc_rx_ready = bus.rx_ready;
  assign bus.rx_data      = bus.noc_rx_flit[FLIT_DATA_W-1:0];
  assign bus.rx_vc        = bus.noc_rx_vc;

`ifdef PKT_PROC_RX_CHK_EN
  logic [NUM_VC-1:0] rx_in_pkt;
  logic [PKT_SZ_W:0] rx_len [NUM_VC];
  logic [NUM_VC-1:0] rx_err;
  logic [NUM_VC-1:0] rx_err_set;
  logic              rx_done;
  logic [VC_W-1:0]   rx_done_vc;
  logic [PKT_SZ_W:0] rx_done_len;
  logic              rx_hs;
  logic [VC_W-1:0]   rx_v;
  flit_type_e        rx_type;
  logic [PKT_SZ_W:0] rx_len_inc;

  assign rx_hs      = bus.noc_rx_valid & bus.rx_ready;
  assign rx_v       = bus.noc_rx_vc;
  assign rx_type    = flit_type_e'(bus.noc_rx_flit[FLIT_W-1 -: 2]);
  assign rx_len_inc = (rx_len[rx_v] == '1) ? rx_len[rx_v] : rx_len[rx_v] + (PKT_SZ_W+1)'(1);

  // A head while a packet is open, or a body/tail with none open, is a framing error.
  always_comb begin
    rx_err_set = '0;
    if (rx_hs) begin
      case (rx_type)
        HEAD, HEAD_TAIL: rx_err_set[rx_v] = rx_in_pkt[rx_v];
        default:         rx_err_set[rx_v] = ~rx_in_pkt[rx_v];
      endcase
    end
  end

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      rx_in_pkt   <= '0;
      for (int v = 0; v < NUM_VC; v++) rx_len[v] <= '0;
      rx_err      <= '0;
      rx_done     <= 1'b0;
      rx_done_vc  <= '0;
      rx_done_len <= '0;
    end else begin
      rx_done <= 1'b0;
      rx_err  <= (rx_err & ~bus.rx_err_clr) | rx_err_set;
      if (rx_hs) begin
        case (rx_type)
          HEAD: begin
            rx_in_pkt[rx_v] <= 1'b1;
            rx_len[rx_v]    <= (PKT_SZ_W+1)'(1);
          end
          BODY: if (rx_in_pkt[rx_v]) rx_len[rx_v] <= rx_len_inc;
          TAIL: if (rx_in_pkt[rx_v]) begin
            rx_in_pkt[rx_v] <= 1'b0;
            rx_done         <= 1'b1;
            rx_done_vc      <= rx_v;
            rx_done_len     <= rx_len_inc;
          end
          HEAD_TAIL: begin
            rx_in_pkt[rx_v] <= 1'b0;
            rx_done         <= 1'b1;
            rx_done_vc      <= rx_v;
            rx_done_len     <= (PKT_SZ_W+1)'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_pkt_done = rx_done;
  assign bus.rx_pkt_vc   = rx_done_vc;
  assign bus.rx_pkt_len  = rx_done_len;
  assign bus.rx_err      = rx_err;
`else
  logic unused_rx_chk;
  assign unused_rx_chk   = ^{bus.rx_err_clr, bus.noc_rx_flit[FLIT_W-1 -: 2]};
  assign bus.rx_pkt_done = 1'b0;
  assign bus.rx_pkt_vc   = '0;
  assign bus.rx_pkt_len  = '0;
  assign bus.rx_err      = '0;
`endif

endmodule

// File: tb/tb_pkt_proc_mvc.sv
// Scoreboard bench for pkt_proc_mvc: TX flits loop back into RX; expectations come
// from a per-VC packet model, monitors compare whenever the DUT presents output.
module tb_pkt_proc_mvc;
  localparam int NUM_VC      = 2;
  localparam int FLIT_DATA_W = 32;
  localparam int PKT_SZ_W    = 8;
  localparam int VC_W        = 1;
  localparam int FLIT_W      = FLIT_DATA_W + 2;
  localparam int LEN_MAX     = (1 << (PKT_SZ_W + 1)) - 1;

  localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

`ifdef PKT_PROC_RX_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk_axi = 1'b0;
  logic arst_axi;
  always #5 clk_axi = ~clk_axi;

  pkt_proc_mvc_if #(.NUM_VC(NUM_VC), .FLIT_DATA_W(FLIT_DATA_W), .PKT_SZ_W(PKT_SZ_W)) bus ();

  pkt_proc_mvc #(.NUM_VC(NUM_VC), .FLIT_DATA_W(FLIT_DATA_W), .PKT_SZ_W(PKT_SZ_W)) dut (
    .clk_axi (clk_axi),
    .arst_axi(arst_axi),
    .bus     (bus)
  );

  // RX input either loops the accepted TX flit back or comes from direct stimulus.
  logic              loop_en = 1'b1;
  logic              rx_drv_valid = 1'b0;
  logic [FLIT_W-1:0] rx_drv_flit = '0;
  logic [VC_W-1:0]   rx_drv_vc = '0;
  assign bus.noc_rx_valid = loop_en ? (bus.noc_tx_valid & bus.noc_tx_ready) : rx_drv_valid;
  assign bus.noc_rx_flit  = loop_en ? bus.noc_tx_flit : rx_drv_flit;
  assign bus.noc_rx_vc    = loop_en ? bus.noc_tx_vc : rx_drv_vc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0]             typ;
    logic [FLIT_DATA_W-1:0] data;
    logic [VC_W-1:0]        vc;
  } flit_t;

  typedef struct packed {
    logic [VC_W-1:0]   vc;
    logic [PKT_SZ_W:0] len;
  } done_t;

  flit_t tx_exp_q[$];
  flit_t rx_exp_q[$];
  done_t done_exp_q[$];

  // Reference model: remaining flit types of each open TX packet, and the flit
  // count of each open RX packet (-1 when none is open).
  logic [1:0]        pend [NUM_VC][$];
  int                open_len [NUM_VC];
  logic [NUM_VC-1:0] err_exp;

  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) begin
      pend[v].delete();
      open_len[v] = -1;
    end
    err_exp = '0;
  endtask

  function automatic logic [NUM_VC-1:0] busy_model();
    logic [NUM_VC-1:0] b = '0;
    for (int v = 0; v < NUM_VC; v++) b[v] = (pend[v].size() != 0);
    return b;
  endfunction

  function automatic logic [1:0] tx_model(input int vc, input int sz);
    if (pend[vc].size() == 0) begin
      if (sz == 0) return T_HT;
      pend[vc].push_back(T_HEAD);
      for (int i = 1; i < sz; i++) pend[vc].push_back(T_BODY);
      pend[vc].push_back(T_TAIL);
    end
    return pend[vc].pop_front();
  endfunction

  task automatic rx_model(input int vc, input logic [1:0] t, input logic [NUM_VC-1:0] clr);
    logic [NUM_VC-1:0] set = '0;
    if (CHK_EN) begin
      case (t)
        T_HEAD: begin
          if (open_len[vc] >= 0) set[vc] = 1'b1;
          open_len[vc] = 1;
        end
        T_BODY: begin
          if (open_len[vc] < 0) set[vc] = 1'b1;
          else open_len[vc] = (open_len[vc] + 1 > LEN_MAX) ? LEN_MAX : open_len[vc] + 1;
        end
        T_TAIL: begin
          if (open_len[vc] < 0) set[vc] = 1'b1;
          else begin
            done_exp_q.push_back('{vc: VC_W'(vc),
                                   len: (PKT_SZ_W+1)'((open_len[vc] + 1 > LEN_MAX) ? LEN_MAX : open_len[vc] + 1)});
            open_len[vc] = -1;
          end
        end
        default: begin
          if (open_len[vc] >= 0) set[vc] = 1'b1;
          done_exp_q.push_back('{vc: VC_W'(vc), len: (PKT_SZ_W+1)'(1)});
          open_len[vc] = -1;
        end
      endcase
    end
    err_exp = (err_exp & ~clr) | set;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk_axi) begin
    if (!arst_axi) begin
      if (bus.noc_tx_valid) begin
        check("tx_ready_follow", 64'(bus.tx_ready), 64'(bus.noc_tx_ready));
        if (tx_exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected: got flit 0x%0h, expected none", bus.noc_tx_flit);
        end else begin
          check("tx_flit", 64'(bus.noc_tx_flit), 64'({tx_exp_q[0].typ, tx_exp_q[0].data}));
          check("tx_vc", 64'(bus.noc_tx_vc), 64'(tx_exp_q[0].vc));
          if (bus.noc_tx_ready) void'(tx_exp_q.pop_front());
        end
      end
      if (bus.noc_rx_valid) begin
        check("rx_valid_follow", 64'(bus.rx_valid), 64'(bus.noc_rx_valid));
        check("rx_ready_follow", 64'(bus.noc_rx_ready), 64'(bus.rx_ready));
        if (rx_exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rx_unexpected: got data 0x%0h, expected none", bus.rx_data);
        end else begin
          check("rx_data", 64'(bus.rx_data), 64'(rx_exp_q[0].data));
          check("rx_vc", 64'(bus.rx_vc), 64'(rx_exp_q[0].vc));
          if (bus.rx_ready) void'(rx_exp_q.pop_front());
        end
      end
      if (bus.rx_pkt_done) begin
        if (done_exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_unexpected: got vc %0d len %0d, expected none", bus.rx_pkt_vc, bus.rx_pkt_len);
        end else begin
          check("done_vc", 64'(bus.rx_pkt_vc), 64'(done_exp_q[0].vc));
          check("done_len", 64'(bus.rx_pkt_len), 64'(done_exp_q[0].len));
          void'(done_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tx_beat(input int vc, input int sz, input int stall);
    logic [1:0]             t;
    logic [FLIT_DATA_W-1:0] d = FLIT_DATA_W'($urandom());
    logic [NUM_VC-1:0]      busy_before = busy_model();
    t = tx_model(vc, sz);
    tx_exp_q.push_back('{typ: t, data: d, vc: VC_W'(vc)});
    rx_exp_q.push_back('{typ: t, data: d, vc: VC_W'(vc)});
    rx_model(vc, t, '0);
    loop_en          = 1'b1;
    bus.tx_valid     = 1'b1;
    bus.tx_data      = d;
    bus.tx_vc        = VC_W'(vc);
    bus.tx_pkt_sz    = PKT_SZ_W'(sz);
    bus.noc_tx_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk_axi); #1;
      check("tx_busy_stall", 64'(bus.tx_busy), 64'(busy_before));
    end
    bus.noc_tx_ready = 1'b1;
    @(posedge clk_axi); #1;
    bus.tx_valid = 1'b0;
    check("tx_busy", 64'(bus.tx_busy), 64'(busy_model()));
    check("rx_err", 64'(bus.rx_err), 64'(err_exp));
  endtask

  task automatic rx_beat(input int vc, input logic [1:0] t, input logic [NUM_VC-1:0] clr);
    logic [FLIT_DATA_W-1:0] d = FLIT_DATA_W'($urandom());
    rx_exp_q.push_back('{typ: t, data: d, vc: VC_W'(vc)});
    rx_model(vc, t, clr);
    loop_en        = 1'b0;
    rx_drv_valid   = 1'b1;
    rx_drv_flit    = {t, d};
    rx_drv_vc      = VC_W'(vc);
    bus.rx_err_clr = clr;
    @(posedge clk_axi); #1;
    rx_drv_valid   = 1'b0;
    bus.rx_err_clr = '0;
    loop_en        = 1'b1;
    check("rx_err", 64'(bus.rx_err), 64'(err_exp));
  endtask

  task automatic clr_only(input logic [NUM_VC-1:0] clr);
    bus.rx_err_clr = clr;
    err_exp = err_exp & ~clr;
    @(posedge clk_axi); #1;
    bus.rx_err_clr = '0;
    check("rx_err_clr", 64'(bus.rx_err), 64'(err_exp));
  endtask

  initial begin
    model_reset();
    arst_axi         = 1'b1;
    bus.tx_valid     = 1'b0;
    bus.tx_data      = '0;
    bus.tx_vc        = '0;
    bus.tx_pkt_sz    = '0;
    bus.noc_tx_ready = 1'b1;
    bus.rx_ready     = 1'b1;
    bus.rx_err_clr   = '0;
    repeat (2) @(posedge clk_axi);
    #1;
    check("rst_busy", 64'(bus.tx_busy), 64'(busy_model()));
    check("rst_done", 64'(bus.rx_pkt_done), 64'(0));
    check("rst_pkt_vc", 64'(bus.rx_pkt_vc), 64'(0));
    check("rst_pkt_len", 64'(bus.rx_pkt_len), 64'(0));
    check("rst_err", 64'(bus.rx_err), 64'(err_exp));
    arst_axi = 1'b0;
    @(posedge clk_axi); #1;

    // VC0 four-flit packet, then a single-flit packet on VC1.
    for (int i = 0; i < 4; i++) tx_beat(0, 3, 0);
    tx_beat(1, 0, 0);

    // Interleaved packets: VC1 completes first (len 2), then VC0 (len 3).
    tx_beat(0, 2, 0);
    tx_beat(1, 1, 0);
    tx_beat(0, 2, 0);
    tx_beat(1, 1, 0);
    tx_beat(0, 2, 0);

    // Head held off by the router for three cycles.
    tx_beat(0, 2, 3);
    tx_beat(0, 7, 1);
    tx_beat(0, 9, 0);

    // Framing errors, clear racing a new error, clear alone.
    rx_beat(0, T_BODY, '0);
    rx_beat(0, T_BODY, 2'b01);
    clr_only(2'b01);
    rx_beat(1, T_TAIL, '0);
    rx_beat(0, T_HEAD, '0);
    rx_beat(0, T_HEAD, '0);
    rx_beat(0, T_TAIL, '0);
    clr_only(2'b11);

    // Length saturation on a very long received packet.
    rx_beat(1, T_HEAD, '0);
    for (int i = 0; i < LEN_MAX + 10; i++) rx_beat(1, T_BODY, '0);
    rx_beat(1, T_TAIL, '0);

    // Randomized TX traffic with stalls, then random raw RX flits.
    for (int i = 0; i < 200; i++)
      tx_beat(int'($urandom_range(0, NUM_VC - 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    for (int i = 0; i < 40; i++)
      rx_beat(int'($urandom_range(0, NUM_VC - 1)), 2'($urandom_range(0, 3)), NUM_VC'($urandom_range(0, 3)));

    // Reset in the middle of a VC0 packet with two flits outstanding.
    clr_only(2'b11);
    for (int v = 0; v < NUM_VC; v++)
      while (pend[v].size() != 0) tx_beat(v, 0, 0);
    tx_beat(0, 3, 0);
    tx_beat(0, 3, 0);
    arst_axi = 1'b1;
    model_reset();
    #1;
    check("mid_rst_busy", 64'(bus.tx_busy), 64'(busy_model()));
    check("mid_rst_err", 64'(bus.rx_err), 64'(err_exp));
    @(posedge clk_axi); #1;
    arst_axi = 1'b0;
    @(posedge clk_axi); #1;
    tx_beat(0, 1, 0);
    tx_beat(0, 1, 0);

    repeat (3) @(posedge clk_axi);
    #1;
    check("tx_q_empty", 64'(tx_exp_q.size()), 64'(0));
    check("rx_q_empty", 64'(rx_exp_q.size()), 64'(0));
    check("done_q_empty", 64'(done_exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
